// File: rtl/acc_pkg.sv
// acc_pkg: shared activation encodings and default widths for the accelerator output path
package acc_pkg;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  localparam int MULT_W = 16;
  typedef enum logic [1:0] {
    ACT_LINEAR = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10,
    ACT_CLIP   = 2'b11
  } act_e;
endpackage

// File: rtl/requant_lane.sv
// requant_lane: one lane of bias add, activation, requant multiply, rounding shift and saturation
module requant_lane import acc_pkg::*; #(
  parameter int ACC_W = acc_pkg::ACC_W,
  parameter int MULT_W = acc_pkg::MULT_W,
  parameter int OUT_W = acc_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en1,
  input  logic              en2,
  input  logic              en3,
  input  logic              en4,
  input  logic [ACC_W-1:0]  in_data,
  input  logic [ACC_W-1:0]  bias_in,
  input  logic              bias_en,
  input  logic [1:0]        act_mode,
  input  logic [2:0]        leaky_shift,
  input  logic [ACC_W-1:0]  clip_max,
  input  logic [MULT_W-1:0] scale,
  input  logic [4:0]        shift,
  input  logic [OUT_W-1:0]  zero_point,
  output logic [OUT_W-1:0]  q,
  output logic              sat
);
  localparam int BW = ACC_W + 1;
  localparam int PW = ACC_W + MULT_W + 2;
  localparam int RW = PW + 2;
  localparam logic signed [RW-1:0] QMAX = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] QMIN = -QMAX - RW'(1);
  logic signed [BW-1:0] b, a, a_n, be, lk, cm;
  logic signed [PW-1:0] p;
  logic signed [RW-1:0] rnd, qw;
  always_comb begin
    be = bias_en ? BW'($signed(bias_in)) : '0;
    lk = b >>> leaky_shift;
    cm = BW'(clip_max);
    a_n = act_mode == ACT_LINEAR ? b :
          b[BW-1] ? (act_mode == ACT_LEAKY ? lk : '0) :
          (act_mode == ACT_CLIP && b > cm) ? cm : b;
    // half an LSB of the shifted result; zero when shift is 0
    rnd = (RW'(1) << shift) >>> 1;
    qw = ((RW'(p) + rnd) >>> shift) + RW'($signed(zero_point));
    sat = qw > QMAX || qw < QMIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      b <= '0;
      a <= '0;
      p <= '0;
      q <= '0;
    end else begin
      if (en1) b <= BW'($signed(in_data)) + be;
      if (en2) a <= a_n;
      if (en3) p <= PW'(a) * PW'($signed({1'b0, scale}));
      if (en4) q <= sat ? (qw[RW-1] ? OUT_W'(QMIN) : OUT_W'(QMAX)) : qw[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/requant_act_pipe.sv
// requant_act_pipe: four-stage valid/ready requant + activation pipeline over LANES lanes
module requant_act_pipe import acc_pkg::*; #(
  parameter int LANES = 4,
  parameter int ACC_W = acc_pkg::ACC_W,
  parameter int MULT_W = acc_pkg::MULT_W,
  parameter int OUT_W = acc_pkg::OUT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic                   in_last,
  input  logic                   bias_en,
  input  logic [LANES*ACC_W-1:0] bias_in,
  input  logic [1:0]             act_mode,
  input  logic [2:0]             leaky_shift,
  input  logic [ACC_W-1:0]       clip_max,
  input  logic [MULT_W-1:0]      scale,
  input  logic [4:0]             shift,
  input  logic [OUT_W-1:0]       zero_point,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last,
  output logic                   idle,
  input  logic                   clr_stats,
  output logic [31:0]            sat_cnt
);
  logic [4:1] v, lp, ld, en;
  logic ld1, ld2, ld3, ld4;
  logic [LANES-1:0] sat;
  logic [32:0] sum;
  assign ld4 = !v[4] | out_ready;
  assign ld3 = !v[3] | ld4;
  assign ld2 = !v[2] | ld3;
  assign ld1 = !v[1] | ld2;
  assign ld = {ld4, ld3, ld2, ld1};
  assign en = ld & {v[3:1], in_valid};
  assign in_ready = ld1;
  assign out_valid = v[4];
  assign out_last = lp[4];
  assign idle = ~|v;
  always_comb begin
    sum = {1'b0, sat_cnt};
    for (int k = 0; k < LANES; k++) sum += 33'(sat[k] & en[4]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      lp <= '0;
      sat_cnt <= '0;
    end else begin
      v <= (ld & {v[3:1], in_valid}) | (~ld & v);
      lp <= (en & {lp[3:1], in_last}) | (~en & lp);
      sat_cnt <= clr_stats ? '0 : sum[32] ? '1 : sum[31:0];
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(.ACC_W(ACC_W), .MULT_W(MULT_W), .OUT_W(OUT_W)) u_lane (
      .clk(clk), .rst(rst),
      .en1(en[1]), .en2(en[2]), .en3(en[3]), .en4(en[4]),
      .in_data(in_data[i*ACC_W +: ACC_W]), .bias_in(bias_in[i*ACC_W +: ACC_W]),
      .bias_en(bias_en), .act_mode(act_mode), .leaky_shift(leaky_shift),
      .clip_max(clip_max), .scale(scale), .shift(shift), .zero_point(zero_point),
      .q(out_data[i*OUT_W +: OUT_W]), .sat(sat[i])
    );
  end
endmodule
